// File: rtl/instr_enc_pkg.sv
// -----------------------------------------------------------------------------
// instr_enc_pkg
// Shared constants and types for the instruction encoder / program loader.
//   - op field codes (data-processing, memory, branch)
//   - data-processing command codes the control decoder implements
//   - the "always" condition code
//   - the loader FSM state encoding
//   - helper that says whether a DP command is supported
// -----------------------------------------------------------------------------
package instr_enc_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_AL = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

  // The decoder only implements these four DP commands; everything else
  // in the cmd space has to be rejected at load time.
  function automatic logic dp_cmd_supported(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
           (cmd == CMD_AND) || (cmd == CMD_ORR);
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Purely combinational field packer. Turns one instruction field bundle into
// a 32-bit machine word and flags whether the encoding is one the control
// decoder implements.
// Optional macro: ENC_BRANCH_REL_EN -- when defined, the branch imm24 input is
// an absolute target word address and is converted to the PC-relative offset
// target - (ptr + 2); otherwise imm24 is copied verbatim.
// Ports:
//   cond/op/funct/rn/rd/src2/imm24 : instruction fields
//   ptr       : word address this word will be written to
//   word      : packed 32-bit instruction
//   supported : 1 when the bundle is a legal encoding
// -----------------------------------------------------------------------------
module instr_pack
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic [3:0]        cond,
  input  logic [1:0]        op,
  input  logic [5:0]        funct,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [11:0]       src2,
  input  logic [23:0]       imm24,
  input  logic [ADDR_W-1:0] ptr,
  output logic [31:0]       word,
  output logic              supported
);

  logic [23:0] br_off;

`ifdef ENC_BRANCH_REL_EN
  // The CPU reads PC as the current word + 2, so the offset is relative to that.
  assign br_off = imm24 - (24'(ptr) + 24'd2);
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign br_off     = imm24;
`endif

  always_comb begin
    word      = {cond, op, funct, rn, rd, src2};
    supported = 1'b0;
    case (op)
      OP_DP:   supported = dp_cmd_supported(funct[4:1]);
      OP_MEM:  supported = 1'b1;
      OP_BR: begin
        word      = {cond, OP_BR, funct[5:4], br_off};
        // Only plain B (no link) is implemented.
        supported = (funct[5:4] == 2'b10);
      end
      default: supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Sequential instruction encoder and program loader. Accepts field bundles on
// a valid/ready stream, packs them via instr_pack, and writes the words
// sequentially into instruction memory while holding the CPU in reset.
// Unsupported bundles are consumed but not written and set a sticky error.
// Optional macro: ENC_BRANCH_REL_EN (relative branch offset conversion, see
// instr_pack).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start           : pulse, begins a load session
//   in_valid/ready  : bundle handshake; in_last marks the final instruction
//   in_*            : instruction fields
//   imem_we/addr/wdata : instruction memory write port
//   cpu_hold        : high while a session is active
//   done            : one-cycle pulse at session end
//   full            : memory capacity reached
//   err             : sticky, an unsupported bundle was rejected
//   count           : words written this session
// -----------------------------------------------------------------------------
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_cond,
  input  logic [1:0]        in_op,
  input  logic [5:0]        in_funct,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [11:0]       in_src2,
  input  logic [23:0]       in_imm24,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   CAP      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              full_q, full_d;
  logic              last_q, last_d;

  logic [31:0]       pack_word;
  logic              pack_ok;
  logic [ADDR_W-1:0] eff_ptr;
  logic [ADDR_W:0]   count_inc;
  logic              hs;

  // A word accepted while the previous one is still being written lands one
  // address further on, so the relative branch offset must use that address.
  assign eff_ptr   = we_q ? ptr_q + 1'b1 : ptr_q;
  assign count_inc = count_q + 1'b1;

  // Ready must also account for a pending write, otherwise a back-to-back
  // bundle could overrun the last free slot.
  assign in_ready = (state_q == ST_LOAD) && !full_q && !last_q &&
                    ((count_q + {{ADDR_W{1'b0}}, we_q}) != CAP);
  assign hs       = in_valid && in_ready;

  instr_pack #(.ADDR_W(ADDR_W)) u_pack (
    .cond      (in_cond),
    .op        (in_op),
    .funct     (in_funct),
    .rn        (in_rn),
    .rd        (in_rd),
    .src2      (in_src2),
    .imm24     (in_imm24),
    .ptr       (eff_ptr),
    .word      (pack_word),
    .supported (pack_ok)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    err_d   = err_q;
    full_d  = full_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = BASE_PTR;
          count_d = '0;
          err_d   = 1'b0;
          full_d  = 1'b0;
          last_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        // Write cycle of a previously accepted bundle.
        if (we_q) begin
          ptr_d   = ptr_q + 1'b1;
          count_d = count_inc;
          if (count_inc == CAP) begin
            full_d  = 1'b1;
            state_d = ST_DONE;
          end
          if (last_q) state_d = ST_DONE;
        end
        if (hs) begin
          if (pack_ok) begin
            we_d    = 1'b1;
            wdata_d = pack_word;
            last_d  = in_last;
          end else begin
            err_d = 1'b1;
            if (in_last) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        last_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= BASE_PTR;
      count_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      full_q  <= full_d;
      last_q  <= last_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = ptr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign full       = full_q;
  assign err        = err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder. A second instance with ADDR_W=2
// exercises the capacity limit.
module tb_instr_encoder;
  import instr_enc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, in_valid, in_last;
  logic [3:0]  in_cond, in_rn, in_rd;
  logic [1:0]  in_op;
  logic [5:0]  in_funct;
  logic [11:0] in_src2;
  logic [23:0] in_imm24;

  logic        in_ready, imem_we, cpu_hold, done, full, err;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [6:0]  count;

  logic        start_b, in_valid_b;
  logic        in_ready_b, imem_we_b, cpu_hold_b, done_b, full_b, err_b;
  logic [1:0]  imem_addr_b;
  logic [31:0] imem_wdata_b;
  logic [2:0]  count_b;

  int checks = 0;
  int passes = 0;

  instr_encoder #(.ADDR_W(6), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_cond(in_cond), .in_op(in_op),
    .in_funct(in_funct), .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2),
    .in_imm24(in_imm24), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .full(full),
    .err(err), .count(count)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .in_last(in_last), .in_cond(in_cond), .in_op(in_op),
    .in_funct(in_funct), .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2),
    .in_imm24(in_imm24), .imem_we(imem_we_b), .imem_addr(imem_addr_b),
    .imem_wdata(imem_wdata_b), .cpu_hold(cpu_hold_b), .done(done_b),
    .full(full_b), .err(err_b), .count(count_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic setFields(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] n, input logic [3:0] d, input logic [11:0] s2,
                           input logic [23:0] i24, input logic last);
    in_cond = c; in_op = o; in_funct = f; in_rn = n; in_rd = d;
    in_src2 = s2; in_imm24 = i24; in_last = last;
  endtask

  // Present one bundle to the main DUT and hold it until it is taken.
  task automatic applyStimulus(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                               input logic [3:0] n, input logic [3:0] d, input logic [11:0] s2,
                               input logic [23:0] i24, input logic last);
    int waited;
    setFields(c, o, f, n, d, s2, i24, last);
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) checkOutput("ready_timeout", 32'(in_ready), 32'd1);
    else tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int hs_b;
    int wr_q[$];
    bit seen_done_b;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; start_b = 1'b0; in_valid_b = 1'b0;
    setFields(4'h0, 2'b00, 6'h0, 4'h0, 4'h0, 12'h0, 24'h0, 1'b0);
    tick(); tick();
    checkOutput("rst_we", 32'(imem_we), 32'd0);
    checkOutput("rst_hold", 32'(cpu_hold), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    // Session 1: single ADD R1,R2,#5 marked last
    pulseStart();
    checkOutput("load_hold", 32'(cpu_hold), 32'd1);
    checkOutput("load_ready", 32'(in_ready), 32'd1);
    applyStimulus(COND_AL, OP_DP, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b1);
    checkOutput("add_we", 32'(imem_we), 32'd1);
    checkOutput("add_addr", 32'(imem_addr), 32'd0);
    checkOutput("add_wdata", imem_wdata, 32'hE2821005);
    tick();
    checkOutput("add_count", 32'(count), 32'd1);
    checkOutput("add_done", 32'(done), 32'd1);
    checkOutput("add_we_off", 32'(imem_we), 32'd0);
    checkOutput("add_wdata_hold", imem_wdata, 32'hE2821005);
    tick();
    checkOutput("add_done_off", 32'(done), 32'd0);
    checkOutput("add_hold_off", 32'(cpu_hold), 32'd0);

    // Session 2: SUBS then LDR (last), back to back
    pulseStart();
    applyStimulus(COND_AL, OP_DP, 6'b000101, 4'd3, 4'd3, 12'h004, 24'h0, 1'b0);
    checkOutput("subs_addr", 32'(imem_addr), 32'd0);
    checkOutput("subs_wdata", imem_wdata, 32'hE0533004);
    applyStimulus(COND_AL, OP_MEM, 6'b011001, 4'd1, 4'd0, 12'h008, 24'h0, 1'b1);
    checkOutput("ldr_we", 32'(imem_we), 32'd1);
    checkOutput("ldr_addr", 32'(imem_addr), 32'd1);
    checkOutput("ldr_wdata", imem_wdata, 32'hE5910008);
    tick();
    checkOutput("s2_done", 32'(done), 32'd1);
    checkOutput("s2_hold", 32'(cpu_hold), 32'd1);
    tick();
    checkOutput("s2_hold_off", 32'(cpu_hold), 32'd0);
    checkOutput("s2_count", 32'(count), 32'd2);

    // Session 3: op=11 rejected mid-stream; next word takes the next address
    pulseStart();
    applyStimulus(COND_AL, OP_DP, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b0);
    checkOutput("s3_first_addr", 32'(imem_addr), 32'd0);
    applyStimulus(COND_AL, 2'b11, 6'b000000, 4'd0, 4'd0, 12'h000, 24'h0, 1'b0);
    checkOutput("rej_we", 32'(imem_we), 32'd0);
    checkOutput("rej_err", 32'(err), 32'd1);
    applyStimulus(COND_AL, OP_DP, 6'b011000, 4'd5, 4'd6, 12'h007, 24'h0, 1'b1);
    checkOutput("s3_next_addr", 32'(imem_addr), 32'd1);
    checkOutput("s3_next_wdata", imem_wdata, 32'hE1856007);
    tick(); tick();
    checkOutput("s3_count", 32'(count), 32'd2);
    checkOutput("s3_err_sticky", 32'(err), 32'd1);
    pulseStart();
    checkOutput("start_clr_err", 32'(err), 32'd0);

    // Rejected BL marked last ends the session without a write
    applyStimulus(COND_AL, OP_BR, 6'b110000, 4'd0, 4'd0, 12'h000, 24'h000010, 1'b1);
    checkOutput("bl_we", 32'(imem_we), 32'd0);
    checkOutput("bl_err", 32'(err), 32'd1);
    checkOutput("bl_done", 32'(done), 32'd1);
    tick();

    // Session 4: four words then a branch at address 4
    pulseStart();
    for (int i = 0; i < 4; i++)
      applyStimulus(COND_AL, OP_DP, 6'b101000, 4'd2, 4'd1, 12'(i), 24'h0, 1'b0);
`ifdef ENC_BRANCH_REL_EN
    applyStimulus(COND_AL, OP_BR, 6'b100000, 4'd0, 4'd0, 12'h000, 24'h000000, 1'b1);
    checkOutput("br_wdata", imem_wdata, 32'hEAFFFFFA);
`else
    applyStimulus(COND_AL, OP_BR, 6'b100000, 4'd0, 4'd0, 12'h000, 24'h000010, 1'b1);
    checkOutput("br_wdata", imem_wdata, 32'hEA000010);
`endif
    checkOutput("br_addr", 32'(imem_addr), 32'd4);
    checkOutput("br_we", 32'(imem_we), 32'd1);
    tick(); tick();
    checkOutput("br_count", 32'(count), 32'd5);

    // Capacity: ADDR_W=2 instance, stream without in_last
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    setFields(COND_AL, OP_DP, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b0);
    in_valid_b = 1'b1;
    hs_b = 0;
    seen_done_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (in_ready_b && hs_b < 5) hs_b++;
      if (hs_b >= 5) in_valid_b = 1'b0;
      tick();
      if (imem_we_b) wr_q.push_back(int'(imem_addr_b));
      if (done_b) seen_done_b = 1'b1;
    end
    in_valid_b = 1'b0;
    checkOutput("cap_handshakes", 32'(hs_b), 32'd4);
    checkOutput("cap_writes", 32'(wr_q.size()), 32'd4);
    for (int i = 0; i < wr_q.size() && i < 4; i++)
      checkOutput($sformatf("cap_addr%0d", i), 32'(wr_q[i]), 32'(i));
    checkOutput("cap_done", 32'(seen_done_b), 32'd1);
    checkOutput("cap_full", 32'(full_b), 32'd1);
    checkOutput("cap_count", 32'(count_b), 32'd4);
    checkOutput("cap_ready", 32'(in_ready_b), 32'd0);

    // Reset right after a handshake discards the pending write
    pulseStart();
    applyStimulus(COND_AL, OP_DP, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b0);
    checkOutput("rst_pend_we", 32'(imem_we), 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("rst_mid_we", 32'(imem_we), 32'd0);
    checkOutput("rst_mid_hold", 32'(cpu_hold), 32'd0);
    checkOutput("rst_mid_count", 32'(count), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("rst_mid_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_mid_we2", 32'(imem_we), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential ARMv4-subset instruction encoder and program loader; the producing end of the instruction format our control decoder consumes.
- Accepts instruction fields over a valid/ready stream and packs them into 32-bit machine words.
- Writes the words sequentially into instruction memory while holding the CPU in reset.
- Rejects encodings the decoder does not implement.

Parameters:
- ADDR_W, 6, instruction memory word-address width (capacity 2^ADDR_W words).
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load session
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- in_last  in  1  bundle is the final instruction of the program
- in_cond  in  4  condition field
- in_op  in  2  op field (00 data-processing, 01 memory, 10 branch)
- in_funct  in  6  funct field
- in_rn  in  4  Rn
- in_rd  in  4  Rd
- in_src2  in  12  Src2 (imm8+rot or shifted register)
- in_imm24  in  24  branch offset (absolute target word address when ENC_BRANCH_REL_EN)
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_W  write word address
- imem_wdata  out  32  encoded word
- cpu_hold  out  1  holds the processor in reset while loading
- done  out  1  one-cycle pulse when the session completes
- full  out  1  memory capacity reached
- err  out  1  sticky: an unsupported bundle was rejected
- count  out  ADDR_W+1  words written this session

Behaviour:
- Reset values: all outputs 0, state IDLE, ptr=BASE_ADDR, count=0.
- States: IDLE, LOAD, DONE.
  - IDLE: cpu_hold=0, in_ready=0. start -> LOAD; clears ptr, count, err, full.
  - LOAD: cpu_hold=1, in_ready=~full. Handshake fires when in_valid & in_ready.
  - DONE: exactly one cycle; done=1, cpu_hold=1; then -> IDLE.
- Word packing:
  - DP and memory: {cond, op, funct, Rn, Rd, Src2}.
  - Branch: {cond, 2'b10, funct[5:4], imm24}.
- Supported encodings:
  - op=00 with funct[4:1] in {0100 ADD, 0010 SUB, 0000 AND, 1100 ORR}.
  - op=01 (any funct).
  - op=10 with funct[5:4]=10 (B; no link).
  - Everything else (op=11, other DP cmd, BL) is rejected.
- Latency: accepted bundle -> imem_we=1 on the next cycle, with imem_addr=ptr and registered imem_wdata. ptr and count increment in that same write cycle.
- Rejected bundle: consumed (handshake completes), nothing written, ptr unchanged, err set sticky. If in_last was set, the session still ends and goes to DONE.
- Accepted bundle with in_last: its write cycle occurs, then DONE.
- Full: asserted when count reaches 2^ADDR_W, i.e. the write at the top address wraps ptr to 0. in_ready then drops. The session goes to DONE automatically without waiting for in_last. No wrap-around overwrite ever occurs.
- start while in LOAD or DONE: ignored.
- reset mid-session: pending write is discarded and imem_we is 0 from the next edge; cpu_hold drops; state returns to IDLE.
- imem_wdata holds its last value when imem_we=0.

Optional Feature:
- Macro: ENC_BRANCH_REL_EN.
- Defined: for branches, in_imm24 is an absolute target word address, zero-extended. Encoder emits imm24 = target - (ptr_of_this_word + 2), two's complement, truncated to 24 bits.
- Undefined: in_imm24 is copied verbatim into the word.

Decomposition:
- Package instr_enc_pkg holds:
  - op constants: OP_DP=2'b00, OP_MEM=2'b01, OP_BR=2'b10.
  - DP command constants: CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR.
  - cond constant COND_AL=4'hE.
  - state enum.
- One sub-module, instr_pack: purely combinational; fields (+ptr) in -> 32-bit word + supported flag out.
- FSM, pointer and handshake stay in instr_encoder.

Test Plan:
- ADD R1,R2,#5: start; bundle cond=E, op=00, funct=101000, rn=2, rd=1, src2=005 -> next cycle imem_we=1, addr=0, wdata=0xE2821005; count=1.
- SUBS R3,R3,R4 then LDR R0,[R1,#8] with in_last: funct=000101 (src2=004), then op=01 funct=011001 (src2=008) -> writes 0xE0533004 @0 and 0xE5910008 @1; done pulse; cpu_hold falls; count=2.
- Unsupported op=11 mid-stream -> no imem_we for it, err=1, next valid bundle lands at the unskipped address; start clears err.
- Capacity with ADDR_W=2: stream 5 bundles without in_last -> 4 writes to addr 0..3, full=1, in_ready=0 for the 5th, done pulses, no write to addr 0 again.
- Branch with ENC_BRANCH_REL_EN: 4 words loaded, then B target=0 (cond=E, funct=100000) -> wdata=0xEAFFFFFA at addr 4. Without the macro, in_imm24=0x000010 -> 0xEA000010.
- reset asserted the cycle after a handshake -> imem_we stays 0, cpu_hold=0, state IDLE, count=0.
